diferential_cfg_loader: RTL

Serial configuration loader that sits directly upstream of the muxpga cell array. It receives a framed bitstream on a single data pin, captures it into a shadow register, and checks it against a checksum. Only a checksum-verified frame is committed to the active per-cell configuration bus that drives the fabric's cell and routing muxes. While a frame is in flight or after a failed load, the fabric is held disabled.

---
 rtl/diferential_cfg_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/diferential_cfg_loader.sv
// diferential_cfg_loader: serial config loader in front of the muxpga array.
// Hunts a sync word, shifts a payload into a shadow register, verifies an
// XOR checksum and only then commits the shadow to the active config bus.
// Ports:
//   clk       - fabric clock, rising edge
//   reset     - synchronous active-low reset
//   sdi       - serial data, consumed when sdi_en=1
//   sdi_en    - bit strobe
//   abort     - cancels an in-flight frame
//   cfg_out   - active config, cell (r,c) at [(r*COLS+c)*CFG_W +: CFG_W]
//   fabric_en - high after a successful commit
//   busy      - high while a frame is in flight
//   done      - one-cycle pulse on a successful commit
//   err       - sticky checksum-fail flag
module diferential_cfg_loader #(
    parameter int          ROWS  = 3,
    parameter int          COLS  = 3,
    parameter int          CFG_W = 4,
    parameter logic [3:0]  SYNC  = 4'b1010
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        sdi,
    input  logic                        sdi_en,
    input  logic                        abort,
    output logic [ROWS*COLS*CFG_W-1:0]  cfg_out,
    output logic                        fabric_en,
    output logic                        busy,
    output logic                        done,
    output logic                        err
);

    localparam int CELLS = ROWS * COLS;
    localparam int N     = CELLS * CFG_W;
    localparam int MAXC  = (N > CFG_W) ? N : CFG_W;
    localparam int CW    = $clog2(MAXC + 1);

    localparam logic [CW-1:0] LAST_D = CW'(N - 1);
    localparam logic [CW-1:0] LAST_C = CW'(CFG_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK,
        COMMIT
    } state_t;

    state_t             state;
    logic [3:0]         hist;
    logic [3:0]         hist_next;
    logic [N-1:0]       shadow;
    logic [CFG_W-1:0]   csum;
    logic [CFG_W-1:0]   expected;
    logic [CW-1:0]      cnt;

    assign hist_next = {hist[2:0], sdi};

    // Checksum is the XOR of every cell field of the shadow image.
    always_comb begin
        expected = '0;
        for (int i = 0; i < CELLS; i++) begin
            expected = expected ^ shadow[i*CFG_W +: CFG_W];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            hist      <= '0;
            shadow    <= '0;
            csum      <= '0;
            cnt       <= '0;
            cfg_out   <= '0;
            fabric_en <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                // Dropping back to IDLE also clears the sync history.
                state <= IDLE;
                hist  <= '0;
                busy  <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (sdi_en) begin
                            hist <= hist_next;
                            if (hist_next == SYNC) begin
                                state     <= SHIFT;
                                cnt       <= '0;
                                err       <= 1'b0;
                                fabric_en <= 1'b0;
                                busy      <= 1'b1;
                            end
                        end
                    end
                    SHIFT: begin
                        if (sdi_en) begin
                            shadow <= {shadow[N-2:0], sdi};
                            if (cnt == LAST_D) begin
                                state <= CHECK;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    CHECK: begin
                        if (sdi_en) begin
                            csum <= {csum[CFG_W-2:0], sdi};
                            if (cnt == LAST_C) begin
                                state <= COMMIT;
                            end else begin
                                cnt <= cnt + 1'b1;
                            end
                        end
                    end
                    COMMIT: begin
                        if (csum == expected) begin
                            cfg_out   <= shadow;
                            fabric_en <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= IDLE;
                        hist  <= '0;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        hist  <= '0;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
